// File: rtl/mips_pkg.sv
// Shared MIPS32 pipeline definitions: memory-op encodings, MEM-stage FSM states and
// CP0 exception codes, plus small decode helpers used across the MEM stage.
package mips_pkg;

  typedef enum logic [3:0] {
    MEM_OP_NONE = 4'd0,
    MEM_OP_LB   = 4'd1,
    MEM_OP_LBU  = 4'd2,
    MEM_OP_LH   = 4'd3,
    MEM_OP_LHU  = 4'd4,
    MEM_OP_LW   = 4'd5,
    MEM_OP_SB   = 4'd6,
    MEM_OP_SH   = 4'd7,
    MEM_OP_SW   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    MEM_IDLE     = 2'd0,
    MEM_WAIT_ACK = 2'd1,
    MEM_DONE     = 2'd2
  } mem_state_e;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  // Unused encodings 9..15 collapse to NONE so they never start a bus cycle.
  function automatic mem_op_e to_mem_op(input logic [3:0] raw);
    return (raw <= 4'd8) ? mem_op_e'(raw) : MEM_OP_NONE;
  endfunction

  function automatic logic is_load(input mem_op_e op);
    return op inside {MEM_OP_LB, MEM_OP_LBU, MEM_OP_LH, MEM_OP_LHU, MEM_OP_LW};
  endfunction

  function automatic logic is_store(input mem_op_e op);
    return op inside {MEM_OP_SB, MEM_OP_SH, MEM_OP_SW};
  endfunction

  function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] off);
    case (op)
      MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: return off[0];
      MEM_OP_LW, MEM_OP_SW:             return |off;
      default:                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_lane.sv
// Byte-lane steering for the MEM stage: builds byte enables and replicated store data for a
// new request, and extracts/extends the addressed lane of returning load data.
module mem_lane_align
  import mips_pkg::*;
(
  input  mem_op_e     req_op_i,
  input  logic [1:0]  req_off_i,
  input  logic [31:0] store_data_i,
  input  mem_op_e     rsp_op_i,
  input  logic [1:0]  rsp_off_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  sel_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o
);

  logic [7:0]  rsp_byte;
  logic [15:0] rsp_half;

  // NOTE: every output gets a default first so no path through the case can infer a latch.
  always_comb begin
    sel_o   = 4'b0000;
    wdata_o = store_data_i;
    unique case (req_op_i)
      MEM_OP_LB, MEM_OP_LBU, MEM_OP_SB: begin
        sel_o   = 4'b0001 << req_off_i;
        wdata_o = {4{store_data_i[7:0]}};
      end
      MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: begin
        sel_o   = req_off_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{store_data_i[15:0]}};
      end
      MEM_OP_LW, MEM_OP_SW: sel_o = 4'b1111;
      default: ;
    endcase
  end

  assign rsp_byte = rdata_i[{rsp_off_i, 3'b000} +: 8];
  assign rsp_half = rsp_off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    load_data_o = rdata_i;
    unique case (rsp_op_i)
      MEM_OP_LB:  load_data_o = {{24{rsp_byte[7]}}, rsp_byte};
      MEM_OP_LBU: load_data_o = {24'h0, rsp_byte};
      MEM_OP_LH:  load_data_o = {{16{rsp_half[15]}}, rsp_half};
      MEM_OP_LHU: load_data_o = {16'h0, rsp_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: issues one req/ack bus access per memory instruction, stalls
// the pipeline while it is outstanding, and reports misalignment and bus timeouts to CP0.
module mem_access_unit
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [3:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic        flush,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [31:0] mem_rdata,
  output logic        stall_req,
  output logic        addr_err_load,
  output logic        addr_err_store,
  output logic [31:0] bad_vaddr,
  output logic        bus_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  mem_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             flushed_q, flushed_d;
  mem_op_e          op_q, op_d;
  logic [1:0]       off_q, off_d;
  logic             bus_req_q, bus_req_d, bus_we_q, bus_we_d, bus_err_q, bus_err_d;
  logic [3:0]       bus_sel_q, bus_sel_d;
  logic [31:0]      bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
  logic [31:0]      mem_rdata_q, mem_rdata_d, bad_vaddr_q, bad_vaddr_d;

  mem_op_e     op_in;
  logic        access, misaligned;
  logic [3:0]  sel_new;
  logic [31:0] wdata_new, load_data;

  assign op_in      = to_mem_op(mem_op);
  assign access     = op_valid && (op_in != MEM_OP_NONE);
  assign misaligned = is_misaligned(op_in, addr[1:0]);
  assign cnt_inc    = cnt_q + 1'b1;

  mem_lane_align u_lane (
    .req_op_i     (op_in),
    .req_off_i    (addr[1:0]),
    .store_data_i (store_data),
    .rsp_op_i     (op_q),
    .rsp_off_i    (off_q),
    .rdata_i      (bus_rdata),
    .sel_o        (sel_new),
    .wdata_o      (wdata_new),
    .load_data_o  (load_data)
  );

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    flushed_d      = flushed_q;
    op_d           = op_q;
    off_d          = off_q;
    bus_req_d      = bus_req_q;
    bus_we_d       = bus_we_q;
    bus_sel_d      = bus_sel_q;
    bus_addr_d     = bus_addr_q;
    bus_wdata_d    = bus_wdata_q;
    mem_rdata_d    = mem_rdata_q;
    bad_vaddr_d    = bad_vaddr_q;
    bus_err_d      = 1'b0;
    stall_req      = 1'b0;
    addr_err_load  = 1'b0;
    addr_err_store = 1'b0;
    unique case (state_q)
      MEM_IDLE: begin
        if (access && misaligned) begin
          addr_err_load  = is_load(op_in);
          addr_err_store = is_store(op_in);
          bad_vaddr_d    = addr;
        end else if (access && !flush) begin
          stall_req   = 1'b1;
          state_d     = MEM_WAIT_ACK;
          cnt_d       = '0;
          flushed_d   = 1'b0;
          op_d        = op_in;
          off_d       = addr[1:0];
          bus_req_d   = 1'b1;
          bus_we_d    = is_store(op_in);
          bus_sel_d   = sel_new;
          bus_addr_d  = {addr[31:2], 2'b00};
          bus_wdata_d = wdata_new;
        end
      end
      MEM_WAIT_ACK: begin
        stall_req = 1'b1;
        flushed_d = flushed_q | flush;
        if (bus_ack) begin
          // A flushed access still has to finish on the bus, but its result is discarded.
          bus_req_d = 1'b0;
          if (flushed_q || flush) begin
            state_d = MEM_IDLE;
          end else begin
            state_d = MEM_DONE;
            if (is_load(op_q)) mem_rdata_d = load_data;
          end
        end else if (cnt_inc == CNT_W'(TIMEOUT_CYC)) begin
          bus_req_d = 1'b0;
          bus_err_d = 1'b1;
          state_d   = MEM_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      MEM_DONE: state_d = MEM_IDLE;
      default:  state_d = MEM_IDLE;
    endcase
    if (rst) begin
      stall_req      = 1'b0;
      addr_err_load  = 1'b0;
      addr_err_store = 1'b0;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= MEM_IDLE;
      cnt_q       <= '0;
      flushed_q   <= 1'b0;
      op_q        <= MEM_OP_NONE;
      off_q       <= 2'b00;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_sel_q   <= 4'b0000;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      mem_rdata_q <= '0;
      bad_vaddr_q <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      flushed_q   <= flushed_d;
      op_q        <= op_d;
      off_q       <= off_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_sel_q   <= bus_sel_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      mem_rdata_q <= mem_rdata_d;
      bad_vaddr_q <= bad_vaddr_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_sel   = bus_sel_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign mem_rdata = mem_rdata_q;
  assign bus_err   = bus_err_q;
  assign bad_vaddr = (addr_err_load || addr_err_store) ? addr : bad_vaddr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: a transaction-level model checked every cycle,
// plus directed load/store/misalignment/flush/timeout/reset scenarios with literal results.
module tb_mem_access_unit;

  localparam int TO = 64;
  localparam logic [3:0] OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3, OP_LHU = 4'd4,
                         OP_LW = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7, OP_SW = 4'd8;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid, flush, bus_ack;
  logic [3:0]  mem_op;
  logic [31:0] addr, store_data, bus_rdata;
  logic        bus_req, bus_we, stall_req, addr_err_load, addr_err_store, bus_err;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr, bus_wdata, mem_rdata, bad_vaddr;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYC(TO)) dut (
    .clk            (clk),
    .rst            (rst),
    .op_valid       (op_valid),
    .mem_op         (mem_op),
    .addr           (addr),
    .store_data     (store_data),
    .flush          (flush),
    .bus_req        (bus_req),
    .bus_we         (bus_we),
    .bus_sel        (bus_sel),
    .bus_addr       (bus_addr),
    .bus_wdata      (bus_wdata),
    .bus_ack        (bus_ack),
    .bus_rdata      (bus_rdata),
    .mem_rdata      (mem_rdata),
    .stall_req      (stall_req),
    .addr_err_load  (addr_err_load),
    .addr_err_store (addr_err_store),
    .bad_vaddr      (bad_vaddr),
    .bus_err        (bus_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    else n_pass++;
  endtask

  // ---------------- model helpers ----------------
  function automatic int op_size(input logic [3:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 1;
      OP_LH, OP_LHU, OP_SH: return 2;
      OP_LW, OP_SW:         return 4;
      default:              return 0;
    endcase
  endfunction

  function automatic bit op_is_store(input logic [3:0] op);
    return (op >= OP_SB) && (op <= OP_SW);
  endfunction

  function automatic logic [31:0] extend(input logic [3:0] op, input logic [1:0] off,
                                         input logic [31:0] rd);
    logic [31:0] sh;
    sh = rd >> (8 * off);
    case (op)
      OP_LB:   return (sh & 32'hFF)   | (sh[7]  ? 32'hFFFFFF00 : 32'h0);
      OP_LBU:  return sh & 32'hFF;
      OP_LH:   return (sh & 32'hFFFF) | (sh[15] ? 32'hFFFF0000 : 32'h0);
      OP_LHU:  return sh & 32'hFFFF;
      default: return rd;
    endcase
  endfunction

  // ---------------- behavioural model + per-cycle compare ----------------
  bit          m_busy, m_done, m_done_load, m_flushed, m_err, m_we;
  int          m_waits;
  logic [3:0]  m_sel, m_op;
  logic [1:0]  m_off;
  logic [31:0] m_addr, m_wdata, m_rdata, m_bad;
  int          e_sz;
  bit          e_mis, e_idle, e_issue, e_stall, e_ael, e_aes;

  always @(negedge clk) begin
    if (rst) begin
      m_busy = 0; m_done = 0; m_done_load = 0; m_flushed = 0; m_err = 0;
      m_rdata = '0; m_bad = '0; m_waits = 0;
      check("rst_bus_req", bus_req, 0);
      check("rst_bus_we", bus_we, 0);
      check("rst_bus_sel", bus_sel, 0);
      check("rst_bus_addr", bus_addr, 0);
      check("rst_bus_wdata", bus_wdata, 0);
      check("rst_mem_rdata", mem_rdata, 0);
      check("rst_stall", stall_req, 0);
      check("rst_ael", addr_err_load, 0);
      check("rst_aes", addr_err_store, 0);
      check("rst_bad_vaddr", bad_vaddr, 0);
      check("rst_bus_err", bus_err, 0);
    end else begin
      e_sz    = op_valid ? op_size(mem_op) : 0;
      e_mis   = (e_sz == 2 && addr[0]) || (e_sz == 4 && addr[1:0] != 2'b00);
      e_idle  = !m_busy && !m_done;
      e_issue = e_idle && e_sz != 0 && !e_mis && !flush;
      e_stall = m_busy || e_issue;
      e_ael   = e_idle && e_mis && !op_is_store(mem_op);
      e_aes   = e_idle && e_mis && op_is_store(mem_op);

      check("stall_req", stall_req, e_stall);
      check("addr_err_load", addr_err_load, e_ael);
      check("addr_err_store", addr_err_store, e_aes);
      check("bad_vaddr", bad_vaddr, (e_ael || e_aes) ? addr : m_bad);
      check("bus_req", bus_req, m_busy);
      check("bus_err", bus_err, m_err);
      if (m_busy) begin
        check("bus_we", bus_we, m_we);
        check("bus_sel", bus_sel, m_sel);
        check("bus_addr", bus_addr, m_addr);
        if (m_we) check("bus_wdata", bus_wdata, m_wdata);
      end
      if (m_done && m_done_load) check("mem_rdata", mem_rdata, m_rdata);

      m_err = 0;
      if (m_done) begin
        m_done = 0;
      end else if (m_busy) begin
        if (flush) m_flushed = 1;
        m_waits++;
        if (bus_ack) begin
          m_busy = 0;
          if (!m_flushed) begin
            m_done      = 1;
            m_done_load = !m_we;
            if (!m_we) m_rdata = extend(m_op, m_off, bus_rdata);
          end
        end else if (m_waits == TO) begin
          m_busy = 0;
          m_err  = 1;
        end
      end else if (e_issue) begin
        m_busy    = 1;
        m_waits   = 0;
        m_flushed = 0;
        m_we      = op_is_store(mem_op);
        m_sel     = 4'(((1 << e_sz) - 1) << addr[1:0]);
        m_addr    = addr & 32'hFFFF_FFFC;
        m_op      = mem_op;
        m_off     = addr[1:0];
        m_wdata   = (e_sz == 1) ? 32'(store_data[7:0])  * 32'h0101_0101 :
                    (e_sz == 2) ? 32'(store_data[15:0]) * 32'h0001_0001 : store_data;
      end else if (e_ael || e_aes) begin
        m_bad = addr;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one aligned access; acks on WAIT cycle ack_on, flushes on WAIT cycle flush_on.
  // Returns at the negedge of the first non-stalled cycle after the access.
  task automatic do_access(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                           input logic [31:0] rd, input int ack_on, input int flush_on,
                           output int stalls, output logic [3:0] sel_s,
                           output logic [31:0] addr_s, output logic [31:0] wdata_s,
                           output logic we_s);
    int  waits, cyc;
    bit  seen_req, ended;
    waits = 0; cyc = 0; seen_req = 0; ended = 0; stalls = 0;
    sel_s = '0; addr_s = '0; wdata_s = '0; we_s = 1'b0;
    step();
    op_valid = 1'b1; mem_op = op; addr = a; store_data = sd; bus_rdata = rd;
    flush = 1'b0; bus_ack = 1'b0;
    while (!ended && cyc < 200) begin
      @(negedge clk);
      if (stall_req) stalls++;
      else if (stalls > 0) ended = 1;
      if (!ended) begin
        step();
        cyc++;
        if (bus_req) begin
          seen_req = 1; waits++;
          sel_s = bus_sel; addr_s = bus_addr; wdata_s = bus_wdata; we_s = bus_we;
        end else if (seen_req) begin
          op_valid = 1'b0;
        end
        bus_ack = bus_req && (waits == ack_on);
        flush   = bus_req && (waits == flush_on);
      end
    end
    bus_ack = 1'b0; flush = 1'b0; op_valid = 1'b0;
    if (!ended) begin
      n_total++;
      $display("FAIL access_bound: op %0d addr 0x%08h did not finish in 200 cycles", op, a);
    end
  endtask

  task automatic misaligned(input logic [3:0] op, input logic [31:0] a, input bit is_st);
    step();
    op_valid = 1'b1; mem_op = op; addr = a; store_data = 32'h0000_0055;
    @(negedge clk);
    check("mis_ael", addr_err_load, 32'(!is_st));
    check("mis_aes", addr_err_store, 32'(is_st));
    check("mis_bad_vaddr", bad_vaddr, a);
    check("mis_stall", stall_req, 0);
    step();
    op_valid = 1'b0; addr = 32'h0;
    @(negedge clk);
    check("mis_no_req", bus_req, 0);
    check("mis_ael_pulse_end", addr_err_load, 0);
    check("mis_bad_vaddr_held", bad_vaddr, a);
  endtask

  int          st;
  logic [3:0]  s;
  logic [31:0] a_s, w_s;
  logic        we_s;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; op_valid = 1'b0; mem_op = 4'd0; addr = '0; store_data = '0;
    flush = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
    repeat (3) step();
    rst = 1'b0;
    step();
    @(negedge clk);
    check("reset_mem_rdata", mem_rdata, 32'h0);
    check("reset_stall", stall_req, 0);

    do_access(OP_LW, 32'h100, 32'h0, 32'hDEADBEEF, 3, -1, st, s, a_s, w_s, we_s);
    check("lw_stall_cycles", st, 4);
    check("lw_mem_rdata", mem_rdata, 32'hDEADBEEF);
    check("lw_sel", s, 4'b1111);
    check("lw_bus_addr", a_s, 32'h100);
    check("lw_we", we_s, 0);

    do_access(OP_LB, 32'h103, 32'h0, 32'h8000_0000, 1, -1, st, s, a_s, w_s, we_s);
    check("lb_stall_cycles", st, 2);
    check("lb_sel", s, 4'b1000);
    check("lb_mem_rdata", mem_rdata, 32'hFFFF_FF80);
    do_access(OP_LBU, 32'h103, 32'h0, 32'h8000_0000, 2, -1, st, s, a_s, w_s, we_s);
    check("lbu_mem_rdata", mem_rdata, 32'h0000_0080);
    do_access(OP_LH, 32'h102, 32'h0, 32'h8001_7FFF, 2, -1, st, s, a_s, w_s, we_s);
    check("lh_sel", s, 4'b1100);
    check("lh_mem_rdata", mem_rdata, 32'hFFFF_8001);
    do_access(OP_LHU, 32'h100, 32'h0, 32'h1234_8765, 1, -1, st, s, a_s, w_s, we_s);
    check("lhu_mem_rdata", mem_rdata, 32'h0000_8765);
    do_access(OP_LB, 32'h101, 32'h0, 32'h0000_7F00, 1, -1, st, s, a_s, w_s, we_s);
    check("lb_pos_mem_rdata", mem_rdata, 32'h0000_007F);

    // Flushed in WAIT_ACK: bus cycle completes, no DONE, result discarded.
    do_access(OP_LW, 32'h400, 32'h0, 32'h1111_1111, 3, 1, st, s, a_s, w_s, we_s);
    check("flush_wait_stalls", st, 4);
    check("flush_wait_mem_rdata", mem_rdata, 32'h0000_007F);

    // No ack at all: timeout after TO WAIT_ACK cycles.
    do_access(OP_LW, 32'h500, 32'h0, 32'h2222_2222, -1, -1, st, s, a_s, w_s, we_s);
    check("timeout_stalls", st, TO + 1);
    check("timeout_bus_err", bus_err, 1);
    check("timeout_req_dropped", bus_req, 0);
    check("timeout_mem_rdata", mem_rdata, 32'h0000_007F);
    step();
    @(negedge clk);
    check("timeout_err_pulse_end", bus_err, 0);

    // Stray ack while idle is ignored.
    step();
    bus_ack = 1'b1; bus_rdata = 32'h3333_3333;
    step();
    bus_ack = 1'b0;
    @(negedge clk);
    check("stray_ack_req", bus_req, 0);
    check("stray_ack_mem_rdata", mem_rdata, 32'h0000_007F);

    do_access(OP_SH, 32'h202, 32'h1234_ABCD, 32'h0, 1, -1, st, s, a_s, w_s, we_s);
    check("sh_we", we_s, 1);
    check("sh_sel", s, 4'b1100);
    check("sh_wdata", w_s, 32'hABCD_ABCD);
    check("sh_bus_addr", a_s, 32'h200);
    do_access(OP_SB, 32'h205, 32'h0000_00A5, 32'h0, 2, -1, st, s, a_s, w_s, we_s);
    check("sb_sel", s, 4'b0010);
    check("sb_wdata", w_s, 32'hA5A5_A5A5);
    check("sb_bus_addr", a_s, 32'h204);
    do_access(OP_SW, 32'h300, 32'hCAFE_F00D, 32'h0, 1, -1, st, s, a_s, w_s, we_s);
    check("sw_sel", s, 4'b1111);
    check("sw_wdata", w_s, 32'hCAFE_F00D);

    misaligned(OP_LW, 32'h101, 1'b0);
    misaligned(OP_SH, 32'h203, 1'b1);
    misaligned(OP_LHU, 32'h105, 1'b0);
    misaligned(OP_SW, 32'h302, 1'b1);

    // Flush in IDLE blocks issue.
    step();
    op_valid = 1'b1; mem_op = OP_LW; addr = 32'h100; flush = 1'b1;
    @(negedge clk);
    check("idle_flush_stall", stall_req, 0);
    step();
    op_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("idle_flush_no_req", bus_req, 0);

    // Reset in the middle of a wait.
    step();
    op_valid = 1'b1; mem_op = OP_LW; addr = 32'h600;
    step();
    step();
    @(negedge clk);
    check("midwait_req_up", bus_req, 1);
    step();
    rst = 1'b1;
    @(negedge clk);
    check("midwait_rst_req", bus_req, 0);
    check("midwait_rst_stall", stall_req, 0);
    check("midwait_rst_mem_rdata", mem_rdata, 32'h0);
    step();
    rst = 1'b0; op_valid = 1'b0;
    @(negedge clk);
    check("post_rst_req", bus_req, 0);
    do_access(OP_LHU, 32'h106, 32'h0, 32'hBEEF_0000, 1, -1, st, s, a_s, w_s, we_s);
    check("post_rst_lhu", mem_rdata, 32'h0000_BEEF);

    step();
    step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
